microwave_cook_ctrl: RTL and testbench

//  Cook-cycle sequencer for the microwave top. Takes one-cycle button pulses from the debouncers and the sw0 power switch.

---
 rtl/microwave_pkg.sv | 44 ++++
 rtl/sec_tick_gen.sv | 38 +++
 rtl/microwave_cook_ctrl.sv | 161 ++++++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// ============================================================================
// microwave_pkg : shared state encoding, button indices and duty table
// Revision: 1.0
// ============================================================================
`default_nettype none

package microwave_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_L    = 3'd1,
    ACT_R    = 3'd2,
    ACT_U    = 3'd3,
    ACT_D    = 3'd4
  } act_e;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;

  // Indexed by power level; level 3 is full power.
  localparam logic [3:0][7:0] DUTY_TABLE = {8'd255, 8'd192, 8'd128, 8'd64};

  // Only the highest-priority button of a cycle is acted on: L > R > U > D.
  function automatic act_e pick_action(input logic [3:0] b);
    if (b[BTN_L])      return ACT_L;
    else if (b[BTN_R]) return ACT_R;
    else if (b[BTN_U]) return ACT_U;
    else if (b[BTN_D]) return ACT_D;
    else               return ACT_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sec_tick_gen.sv
// ============================================================================
// sec_tick_gen : TICK_DIV prescaler, one-cycle tick on wrap; clr beats en
// Revision: 1.0
// ============================================================================
`default_nettype none

module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = en && !clr && (cnt_q == CNT_MAX);
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/microwave_cook_ctrl.sv
// ============================================================================
// microwave_cook_ctrl : cook-cycle FSM, remaining-time counter, output decode
// Optional feature: POWER_LEVEL_EN (D button selects power level / duty)
// Revision: 1.0
// ============================================================================
`default_nettype none

module microwave_cook_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int STEP_SEC = 30,
  parameter int MAX_SEC  = 5999,
  parameter int DONE_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw0,
  input  logic [3:0] btn,
  output logic       led,
  output logic [1:0] motor_dir,
  output logic [7:0] duty,
  output logic [6:0] time_min,
  output logic [5:0] time_sec,
  output logic       done
);

  localparam int DCNT_W = $clog2(DONE_SEC + 1);

  state_e            state_q, state_d;
  logic [12:0]       rem_q, rem_d, rem_run;
  logic [1:0]        power_q, power_d;
  logic              led_q, led_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              tick, pre_clr, pre_en;
  logic [3:0]        btn_eff;
  act_e              act;

  function automatic logic [12:0] sat_add(input logic [12:0] v);
    logic [13:0] s;
    s = {1'b0, v} + 14'(STEP_SEC);
    return (s > 14'(MAX_SEC)) ? 13'(MAX_SEC) : s[12:0];
  endfunction

`ifdef POWER_LEVEL_EN
  assign btn_eff = btn;
`else
  assign btn_eff = btn & 4'b1011;
`endif

  assign act    = pick_action(btn_eff);
  assign pre_en = (state_q == ST_RUN) || (state_q == ST_DONE);

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    power_d = power_q;
    dcnt_d  = '0;
    pre_clr = 1'b0;
    rem_run = rem_q;
    if (!sw0) begin
      state_d = ST_OFF;
      rem_d   = '0;
      power_d = 2'd3;
      pre_clr = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_IDLE;
        ST_IDLE, ST_PAUSE: begin
          case (act)
            ACT_L: begin
              state_d = ST_IDLE;
              rem_d   = '0;
            end
            ACT_R: begin
              if (state_q == ST_PAUSE) begin
                state_d = ST_RUN;
              end else if (rem_q != '0) begin
                state_d = ST_RUN;
                pre_clr = 1'b1;
              end
            end
            ACT_U:   rem_d   = sat_add(rem_q);
            ACT_D:   power_d = power_q - 2'd1;
            default: ;
          endcase
        end
        ST_RUN: begin
          if (act == ACT_L) begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end else begin
            // Tick and U in one cycle: decrement first, then add and saturate.
            rem_run = rem_q - {12'd0, tick};
            if (act == ACT_U)
              rem_run = sat_add(rem_run);
            rem_d = rem_run;
            if (rem_run == '0)
              state_d = ST_DONE;
            else if (act == ACT_R)
              state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          dcnt_d = dcnt_q;
          if (btn_eff != 4'b0000) begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end else if (tick) begin
            if (dcnt_q == DCNT_W'(DONE_SEC - 1))
              state_d = ST_IDLE;
            else
              dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // LED carries its RUN value into DONE, then flips on every DONE tick.
    led_d = 1'b0;
    if (state_d == ST_RUN)
      led_d = 1'b1;
    else if (state_d == ST_DONE)
      led_d = (state_q == ST_DONE && tick) ? ~led_q : led_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      rem_q   <= '0;
      power_q <= 2'd3;
      led_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      power_q <= power_d;
      led_q   <= led_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign led       = led_q;
  assign motor_dir = (state_q == ST_RUN) ? 2'b01 : 2'b00;
  assign duty      = (state_q == ST_RUN) ? DUTY_TABLE[power_q] : 8'd0;
  assign time_min  = 7'(rem_q / 13'd60);
  assign time_sec  = 6'(rem_q % 13'd60);
  assign done      = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_microwave_cook_ctrl.sv
// ============================================================================
// tb_microwave_cook_ctrl : scoreboard bench with a behavioural cook model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_microwave_cook_ctrl;

  localparam int TICK_DIV = 10;
  localparam int STEP_SEC = 30;
  localparam int MAX_SEC  = 5999;
  localparam int DONE_SEC = 3;

  localparam int M_OFF = 0, M_IDLE = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw0 = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       led;
  logic [1:0] motor_dir;
  logic [7:0] duty;
  logic [6:0] time_min;
  logic [5:0] time_sec;
  logic       done;

  microwave_cook_ctrl #(
    .TICK_DIV (TICK_DIV),
    .STEP_SEC (STEP_SEC),
    .MAX_SEC  (MAX_SEC),
    .DONE_SEC (DONE_SEC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw0       (sw0),
    .btn       (btn),
    .led       (led),
    .motor_dir (motor_dir),
    .duty      (duty),
    .time_min  (time_min),
    .time_sec  (time_sec),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       led;
    logic [1:0] motor_dir;
    logic [7:0] duty;
    logic [6:0] time_min;
    logic [5:0] time_sec;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_no = 0;

  // Behavioural model: mode, remaining seconds, prescaler phase, power level.
  int m_mode = M_OFF, m_rem = 0, m_pre = 0, m_pow = 3, m_dt = 0;
  bit m_led = 0;

  task automatic model_step(input bit r, input bit s, input logic [3:0] b);
    bit         tk;
    int         top;
    int         nr;
    logic [3:0] e;
    if (r || !s) begin
      m_mode = M_OFF; m_rem = 0; m_pre = 0; m_pow = 3; m_led = 0; m_dt = 0;
      return;
    end
    tk = (m_mode == M_RUN || m_mode == M_DONE) && (m_pre == TICK_DIV - 1);
    if (m_mode == M_RUN || m_mode == M_DONE) m_pre = (m_pre + 1) % TICK_DIV;
    e = b;
`ifndef POWER_LEVEL_EN
    e[2] = 1'b0;
`endif
    top = e[1] ? 1 : e[0] ? 0 : e[3] ? 3 : e[2] ? 2 : -1;
    case (m_mode)
      M_OFF: m_mode = M_IDLE;
      M_IDLE, M_PAUSE: begin
        if (top == 1) begin
          m_rem = 0; m_mode = M_IDLE;
        end else if (top == 0) begin
          if (m_mode == M_PAUSE) m_mode = M_RUN;
          else if (m_rem != 0) begin m_mode = M_RUN; m_pre = 0; end
        end else if (top == 3) begin
          m_rem = (m_rem + STEP_SEC > MAX_SEC) ? MAX_SEC : m_rem + STEP_SEC;
        end else if (top == 2) begin
          m_pow = (m_pow + 3) % 4;
        end
      end
      M_RUN: begin
        if (top == 1) begin
          m_rem = 0; m_mode = M_IDLE;
        end else begin
          nr = m_rem - (tk ? 1 : 0);
          if (top == 3) nr = (nr + STEP_SEC > MAX_SEC) ? MAX_SEC : nr + STEP_SEC;
          m_rem = nr;
          if (nr == 0) begin m_mode = M_DONE; m_dt = 0; end
          else if (top == 0) m_mode = M_PAUSE;
        end
      end
      M_DONE: begin
        if (e != 4'b0000) begin
          m_rem = 0; m_mode = M_IDLE;
        end else if (tk) begin
          m_dt++;
          if (m_dt == DONE_SEC) m_mode = M_IDLE;
          else m_led = !m_led;
        end
      end
      default: m_mode = M_OFF;
    endcase
    if (m_mode == M_RUN) m_led = 1;
    else if (m_mode != M_DONE) m_led = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.led       = m_led;
    o.motor_dir = (m_mode == M_RUN) ? 2'b01 : 2'b00;
    o.duty      = (m_mode != M_RUN) ? 8'd0 : (m_pow == 3) ? 8'd255 : 8'(64 * (m_pow + 1));
    o.time_min  = 7'(m_rem / 60);
    o.time_sec  = 6'(m_rem % 60);
    o.done      = (m_mode == M_DONE);
    return o;
  endfunction

  task automatic cyc(input bit r, input bit s, input logic [3:0] b);
    @(negedge clk);
    rst = r; sw0 = s; btn = b;
    model_step(r, s, b);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 4'b0000);
  endtask

  // Monitor: the DUT presents a new output set every clock.
  always @(posedge clk) begin
    obs_t got, want;
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = '{led, motor_dir, duty, time_min, time_sec, done};
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL outputs cycle %0d: got led=%b dir=%b duty=%0d t=%0d:%0d done=%b, want led=%b dir=%b duty=%0d t=%0d:%0d done=%b",
                    cyc_no, got.led, got.motor_dir, got.duty, got.time_min, got.time_sec, got.done,
                    want.led, want.motor_dir, want.duty, want.time_min, want.time_sec, want.done);
    end
  end

  initial begin
    logic [3:0] b;
    bit         s, r;
    // Reset
    cyc(1, 0, 4'b0000); cyc(1, 0, 4'b0000); cyc(0, 0, 4'b0000);
    // 1: two U presses, start, one tick later 0:59
    cyc(0, 1, 4'b0000);
    cyc(0, 1, 4'b1000); cyc(0, 1, 4'b1000);
    cyc(0, 1, 4'b0001);
    idle(12);
    // 2: run down to 2 s, then DONE and auto-return
    for (int k = 0; k < 1000 && m_rem != 2; k++) idle(1);
    idle(70);
    // 3: pause with prescaler at 4, hold, resume
    cyc(0, 1, 4'b1000); cyc(0, 1, 4'b1000); cyc(0, 1, 4'b0001);
    for (int k = 0; k < 1000 && !(m_rem == 45 && m_pre == 4); k++) idle(1);
    cyc(0, 1, 4'b0001);
    idle(50);
    cyc(0, 1, 4'b0001);
    idle(8);
    // 4: saturation, then U on the tick cycle at 0:10
    cyc(0, 1, 4'b0010);
    for (int k = 0; k < 200; k++) cyc(0, 1, 4'b1000);
    idle(2);
    cyc(0, 1, 4'b0010);
    cyc(0, 1, 4'b1000); cyc(0, 1, 4'b0001);
    for (int k = 0; k < 1000 && !(m_rem == 10 && m_pre == TICK_DIV - 1); k++) idle(1);
    cyc(0, 1, 4'b1000);
    idle(5);
    // 5: sw0 drop mid-RUN, then L+R in IDLE
    cyc(0, 0, 4'b0000); cyc(0, 0, 4'b0000);
    cyc(0, 1, 4'b0000);
    cyc(0, 1, 4'b1000); cyc(0, 1, 4'b0011);
    idle(3);
    // 6: power level stepping (duty 128 with the feature, 255 without)
    cyc(0, 1, 4'b0100); cyc(0, 1, 4'b0100);
    cyc(0, 1, 4'b1000); cyc(0, 1, 4'b0001);
    idle(5);
    cyc(0, 1, 4'b0010);
    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      r = ($urandom_range(0, 999) == 0);
      s = ($urandom_range(0, 299) != 0);
      b = 4'b0000;
      if ($urandom_range(0, 7) == 0) begin
        b = 4'($urandom_range(0, 15));
        if (b[1] && $urandom_range(0, 3) != 0) b[1] = 1'b0;
      end
      cyc(r, s, b);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
